qpll_quad_init_ctrl: RTL and testbench

//  Parametrised power-up/reset sequencer for NUM_QUADS GTXE2_COMMON QPLLs. Holds QPLLs in power-down, optionally

---
 rtl/qpll_ctrl_pkg.sv | 24 ++
 rtl/qpll_quad_init_ctrl_if.sv | 25 ++
 rtl/qpll_sync2.sv | 22 ++
 rtl/qpll_quad_init_ctrl.sv | 167 ++++++++++++++++
 tb/tb_qpll_quad_init_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qpll_ctrl_pkg.sv
// Shared types for the QPLL quad init sequencer: FSM state encoding and timer sizing.
// No logic, so no latency or backpressure of its own.
package qpll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_PD        = 3'd0,
        ST_CFG       = 3'd1,
        ST_RST       = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_LOCKED    = 3'd4,
        ST_FAIL      = 3'd5
    } state_e;

    // One shared timer must reach the largest of the cycle parameters without wrapping.
    function automatic int timer_w(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/qpll_quad_init_ctrl_if.sv
// QPLL common + DRP bundle between the init sequencer (master) and the quad wrappers (slave).
// Pure wiring; DRP acknowledge is per quad via DRPRDY.
interface qpll_quad_init_ctrl_if #(
    parameter int NUM_QUADS = 1
);
    logic [NUM_QUADS-1:0]    QPLLLOCK;
    logic [NUM_QUADS-1:0]    QPLLREFCLKLOST;
    logic [NUM_QUADS-1:0]    DRPRDY;
    logic [NUM_QUADS-1:0]    QPLLPD;
    logic [NUM_QUADS-1:0]    QPLLRESET;
    logic [NUM_QUADS-1:0]    DRPEN;
    logic [NUM_QUADS-1:0]    DRPWE;
    logic [8*NUM_QUADS-1:0]  DRPADDR;
    logic [16*NUM_QUADS-1:0] DRPDI;

    modport master (
        input  QPLLLOCK, QPLLREFCLKLOST, DRPRDY,
        output QPLLPD, QPLLRESET, DRPEN, DRPWE, DRPADDR, DRPDI
    );

    modport slave (
        output QPLLLOCK, QPLLREFCLKLOST, DRPRDY,
        input  QPLLPD, QPLLRESET, DRPEN, DRPWE, DRPADDR, DRPDI
    );
endinterface

// File: rtl/qpll_sync2.sv
// Two-flop synchroniser for quasi-static async status bits into the local clock.
// Latency 2 cycles; no backpressure.
module qpll_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/qpll_quad_init_ctrl.sv
// Power-up/reset sequencer for NUM_QUADS QPLL commons: PD, optional DRP cfg, reset, lock wait/retry, lock monitor.
// Lock-in to ALL_LOCKED is 4 cycles; DRP writes wait on DRPRDY with one write outstanding.
module qpll_quad_init_ctrl
    import qpll_ctrl_pkg::*;
#(
    parameter int          NUM_QUADS    = 1,
    parameter int          PD_CYCLES    = 64,
    parameter int          RST_CYCLES   = 16,
    parameter int          LOCK_TIMEOUT = 65536,
    parameter int          DRP_TIMEOUT  = 256,
    parameter int          MAX_RETRIES  = 3,
    parameter int          DRP_CFG_EN   = 0,
    parameter logic [7:0]  CFG_ADDR     = 8'h32,
    parameter logic [15:0] CFG_DATA     = 16'h0
) (
    input  logic                   DRPCLK,
    input  logic                   RESET,
    input  logic                   RESTART,
    qpll_quad_init_ctrl_if.master  qif,
    output logic                   ALL_LOCKED,
    output logic                   FAIL,
    output logic [3:0]             RETRY_CNT,
    output logic [7:0]             LOSS_CNT
);
    localparam int TW = timer_w(PD_CYCLES, RST_CYCLES, LOCK_TIMEOUT, DRP_TIMEOUT);
    localparam int QW = (NUM_QUADS > 1) ? $clog2(NUM_QUADS) : 1;

    state_e                  state, state_nxt;
    logic [TW-1:0]           timer;
    logic                    timer_clr;
    logic [QW-1:0]           quad_idx, quad_idx_nxt;
    logic                    drp_busy, drp_busy_nxt;
    logic                    drp_strobe;
    logic                    timeout;
    logic                    loss_evt;
    logic [3:0]              retry_nxt;
    logic [NUM_QUADS-1:0]    lock_s, lost_s;
    logic                    locks_ok;
    logic [NUM_QUADS-1:0]    drp_en_d;
    logic [8*NUM_QUADS-1:0]  drp_addr_d;
    logic [16*NUM_QUADS-1:0] drp_di_d;

    qpll_sync2 #(.WIDTH(NUM_QUADS)) u_sync_lock (
        .clk (DRPCLK), .rst (RESET), .d (qif.QPLLLOCK), .q (lock_s)
    );

    qpll_sync2 #(.WIDTH(NUM_QUADS)) u_sync_lost (
        .clk (DRPCLK), .rst (RESET), .d (qif.QPLLREFCLKLOST), .q (lost_s)
    );

    assign locks_ok = (&lock_s) && !(|lost_s);

    always_comb begin
        state_nxt    = state;
        timer_clr    = 1'b0;
        quad_idx_nxt = quad_idx;
        drp_busy_nxt = drp_busy;
        drp_strobe   = 1'b0;
        timeout      = 1'b0;
        loss_evt     = 1'b0;
        retry_nxt    = RETRY_CNT;
        if (RESTART) begin
            state_nxt    = ST_PD;
            retry_nxt    = 4'd0;
            drp_busy_nxt = 1'b0;
            quad_idx_nxt = '0;
        end else begin
            case (state)
                ST_PD: begin
                    if (timer == TW'(PD_CYCLES - 1)) begin
                        state_nxt    = (DRP_CFG_EN != 0) ? ST_CFG : ST_RST;
                        quad_idx_nxt = '0;
                        drp_busy_nxt = 1'b0;
                    end
                end
                ST_CFG: begin
                    // The DRP timeout window restarts at each strobe, not at CFG entry.
                    if (!drp_busy) begin
                        drp_strobe   = 1'b1;
                        drp_busy_nxt = 1'b1;
                        timer_clr    = 1'b1;
                    end else if (qif.DRPRDY[quad_idx]) begin
                        drp_busy_nxt = 1'b0;
                        if (quad_idx == QW'(NUM_QUADS - 1)) state_nxt = ST_RST;
                        else quad_idx_nxt = quad_idx + 1'b1;
                    end else if (timer == TW'(DRP_TIMEOUT - 1)) begin
                        timeout = 1'b1;
                    end
                end
                ST_RST: begin
                    if (timer == TW'(RST_CYCLES - 1)) state_nxt = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (locks_ok) begin
                        state_nxt = ST_LOCKED;
                        retry_nxt = 4'd0;
                    end else if (timer == TW'(LOCK_TIMEOUT - 1)) begin
                        timeout = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (!locks_ok) begin
                        loss_evt  = 1'b1;
                        state_nxt = ST_RST;
                    end
                end
                ST_FAIL: ;
                default: state_nxt = ST_PD;
            endcase
            if (timeout) begin
                retry_nxt    = RETRY_CNT + 4'd1;
                state_nxt    = (retry_nxt == 4'(MAX_RETRIES)) ? ST_FAIL : ST_RST;
                drp_busy_nxt = 1'b0;
            end
        end
        if (state_nxt != state || RESTART) timer_clr = 1'b1;
    end

    always_comb begin
        drp_en_d   = '0;
        drp_addr_d = '0;
        drp_di_d   = '0;
        for (int q = 0; q < NUM_QUADS; q++) begin
            if (drp_strobe && quad_idx == QW'(q)) begin
                drp_en_d[q]           = 1'b1;
                drp_addr_d[8*q +: 8]  = CFG_ADDR;
                drp_di_d[16*q +: 16]  = CFG_DATA;
            end
        end
    end

    always_ff @(posedge DRPCLK) begin
        if (RESET) begin
            state         <= ST_PD;
            timer         <= '0;
            quad_idx      <= '0;
            drp_busy      <= 1'b0;
            RETRY_CNT     <= 4'd0;
            LOSS_CNT      <= 8'd0;
            ALL_LOCKED    <= 1'b0;
            FAIL          <= 1'b0;
            qif.QPLLPD    <= '1;
            qif.QPLLRESET <= '1;
            qif.DRPEN     <= '0;
            qif.DRPWE     <= '0;
            qif.DRPADDR   <= '0;
            qif.DRPDI     <= '0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_clr ? '0 : ((&timer) ? timer : timer + 1'b1);
            quad_idx  <= quad_idx_nxt;
            drp_busy  <= drp_busy_nxt;
            RETRY_CNT <= retry_nxt;
            if (loss_evt && LOSS_CNT != 8'hFF) LOSS_CNT <= LOSS_CNT + 8'd1;
            ALL_LOCKED    <= (state == ST_LOCKED);
            FAIL          <= (state == ST_FAIL);
            // Power/reset pins decode the next state so they change on the same edge as the state.
            qif.QPLLPD    <= {NUM_QUADS{state_nxt == ST_PD || state_nxt == ST_FAIL}};
            qif.QPLLRESET <= {NUM_QUADS{state_nxt == ST_PD || state_nxt == ST_RST ||
                                        state_nxt == ST_FAIL}};
            qif.DRPEN     <= drp_en_d;
            qif.DRPWE     <= drp_en_d;
            qif.DRPADDR   <= drp_addr_d;
            qif.DRPDI     <= drp_di_d;
        end
    end
endmodule

// File: tb/tb_qpll_quad_init_ctrl.sv
// Bench for qpll_quad_init_ctrl: randomized lock/DRP responders against pin-level timing rules.
module tb_qpll_quad_init_ctrl;
    localparam int          NQ   = 4;
    localparam int          PDC  = 64;
    localparam int          RSTC = 16;
    localparam int          LTO  = 1000;
    localparam int          DTO  = 256;
    localparam int          MR   = 3;
    localparam logic [7:0]  CA   = 8'h32;
    localparam logic [15:0] CD   = 16'hA5C3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       restart = 1'b0;
    logic       all_locked, fail;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    qpll_quad_init_ctrl_if #(.NUM_QUADS(NQ)) qif ();

    qpll_quad_init_ctrl #(
        .NUM_QUADS(NQ), .PD_CYCLES(PDC), .RST_CYCLES(RSTC), .LOCK_TIMEOUT(LTO),
        .DRP_TIMEOUT(DTO), .MAX_RETRIES(MR), .DRP_CFG_EN(1), .CFG_ADDR(CA), .CFG_DATA(CD)
    ) dut (
        .DRPCLK(clk), .RESET(rst), .RESTART(restart), .qif(qif),
        .ALL_LOCKED(all_locked), .FAIL(fail), .RETRY_CNT(retry_cnt), .LOSS_CNT(loss_cnt)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    int lock_dly [NQ];
    int since_rst = 0, rst_w = 0, rst16_cnt = 0, rst_other_cnt = 0;
    int pd_w = 0, last_pd_w = 0;
    bit prev_rst = 1'b1, prev_pd = 1'b1, prev_al = 1'b0;
    int strobe_q [$];
    int proto_bad = 0;
    logic [NQ-1:0] prev_en = '0;
    int rdy_dly = 3, rdy_cnt = -1, rdy_q = 0;
    bit drp_respond = 1'b1, rdy_noise = 1'b0;
    int last_lock_rise = 0, al_rise = 0;
    int drop_q = -1, lost_q = -1;
    int exp_loss = 0;
    logic [28*NQ+13:0] rst_vec_exp;

    // Advance one cycle, sample outputs, then act as the quads: locks, refclk-lost and DRP acks.
    task automatic tick();
        logic [NQ-1:0]    nl;
        logic [8*NQ-1:0]  ea;
        logic [16*NQ-1:0] ed;
        @(posedge clk);
        #1;
        cyc++;
        if (qif.QPLLPD !== {NQ{qif.QPLLPD[0]}} || qif.QPLLRESET !== {NQ{qif.QPLLRESET[0]}})
            proto_bad++;
        if (qif.QPLLRESET[0]) begin
            rst_w++;
            since_rst = 0;
        end else begin
            if (prev_rst) begin
                if (rst_w == RSTC) rst16_cnt++;
                else rst_other_cnt++;
            end
            rst_w = 0;
            since_rst++;
        end
        prev_rst = qif.QPLLRESET[0];
        if (rst) pd_w = 1;
        else if (qif.QPLLPD[0]) pd_w++;
        else begin
            if (prev_pd) last_pd_w = pd_w;
            pd_w = 0;
        end
        prev_pd = qif.QPLLPD[0];
        qif.DRPRDY = '0;
        if (rdy_cnt > 0) begin
            rdy_cnt--;
            if (rdy_cnt == 0) qif.DRPRDY[rdy_q] = 1'b1;
            else if (rdy_noise && rdy_cnt == 1) qif.DRPRDY[(rdy_q + 1) % NQ] = 1'b1;
        end
        if (qif.DRPWE !== qif.DRPEN) proto_bad++;
        if (qif.DRPEN == '0) begin
            if (qif.DRPADDR !== '0 || qif.DRPDI !== '0) proto_bad++;
        end else begin
            if ($countones(qif.DRPEN) != 1 || prev_en != '0) proto_bad++;
            for (int q = 0; q < NQ; q++) begin
                if (qif.DRPEN[q]) begin
                    ea = '0;
                    ed = '0;
                    ea[8*q +: 8]   = CA;
                    ed[16*q +: 16] = CD;
                    if (qif.DRPADDR !== ea || qif.DRPDI !== ed) proto_bad++;
                    strobe_q.push_back(q);
                    if (drp_respond) begin
                        rdy_cnt = rdy_dly;
                        rdy_q   = q;
                    end
                end
            end
        end
        prev_en = qif.DRPEN;
        for (int q = 0; q < NQ; q++)
            nl[q] = !qif.QPLLRESET[0] && lock_dly[q] >= 0 && since_rst > lock_dly[q] && q != drop_q;
        if ((nl & ~qif.QPLLLOCK) != '0) last_lock_rise = cyc;
        qif.QPLLLOCK = nl;
        drop_q = -1;
        qif.QPLLREFCLKLOST = '0;
        if (lost_q >= 0) qif.QPLLREFCLKLOST[lost_q] = 1'b1;
        lost_q = -1;
        if (all_locked && !prev_al) al_rise = cyc;
        prev_al = all_locked;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++;
        if (qif.QPLLPD !== {NQ{1'b1}} || qif.QPLLRESET !== {NQ{1'b1}}) begin
            bad++;
            $display("FAIL reset_pd_rst: pd=%b rst=%b want all ones", qif.QPLLPD, qif.QPLLRESET);
        end
        total++;
        if (qif.DRPEN !== '0 || qif.DRPWE !== '0 || qif.DRPADDR !== '0 || qif.DRPDI !== '0) begin
            bad++;
            $display("FAIL reset_drp: en=%b we=%b addr=%h di=%h want 0", qif.DRPEN, qif.DRPWE,
                     qif.DRPADDR, qif.DRPDI);
        end
        total++;
        if ({all_locked, fail, retry_cnt, loss_cnt} !== 14'd0) begin
            bad++;
            $display("FAIL reset_status: al=%b fail=%b retry=%0d loss=%0d want 0", all_locked,
                     fail, retry_cnt, loss_cnt);
        end
    endtask

    task automatic test_init();
        for (int it = 0; it < 2; it++) begin
            int n;
            bit ok;
            rst = 1'b1;
            drp_respond = 1'b1;
            rdy_dly = (it == 0) ? 3 : int'($urandom_range(2, 7));
            rdy_noise = (it == 1);
            for (int q = 0; q < NQ; q++) lock_dly[q] = (it == 0) ? 100 : int'($urandom_range(5, 200));
            tick();
            tick();
            strobe_q.delete();
            rst16_cnt = 0;
            rst_other_cnt = 0;
            proto_bad = 0;
            last_pd_w = 0;
            exp_loss = 0;
            rst = 1'b0;
            n = 0;
            while (!all_locked && n < 3000) begin tick(); n++; end
            total++;
            if (!all_locked) begin bad++; $display("FAIL init_lock_timeout: it=%0d al=%b want 1", it, all_locked); end
            total++;
            if (last_pd_w != PDC) begin bad++; $display("FAIL init_pd_width: got %0d want %0d", last_pd_w, PDC); end
            ok = (strobe_q.size() == NQ);
            for (int i = 0; i < strobe_q.size(); i++) if (strobe_q[i] != i) ok = 1'b0;
            total++;
            if (!ok) begin bad++; $display("FAIL init_strobe_order: count=%0d want %0d in order 0..%0d", strobe_q.size(), NQ, NQ-1); end
            total++;
            if (rst16_cnt != 1) begin bad++; $display("FAIL init_rst_pulses: got %0d want 1", rst16_cnt); end
            total++;
            if (al_rise - last_lock_rise != 4) begin bad++; $display("FAIL init_lock_latency: got %0d want 4", al_rise - last_lock_rise); end
            total++;
            if (retry_cnt !== 4'd0 || fail !== 1'b0) begin bad++; $display("FAIL init_status: retry=%0d fail=%b want 0/0", retry_cnt, fail); end
            total++;
            if (proto_bad != 0) begin bad++; $display("FAIL init_protocol: violations=%0d want 0", proto_bad); end
        end
    endtask

    task automatic test_loss();
        for (int k = 0; k < 4; k++) begin
            int n, r0, s0;
            r0 = rst16_cnt;
            s0 = strobe_q.size();
            for (int q = 0; q < NQ; q++) lock_dly[q] = $urandom_range(5, 200);
            if ($urandom_range(0, 1) == 0) drop_q = $urandom_range(0, NQ-1);
            else lost_q = $urandom_range(0, NQ-1);
            exp_loss++;
            n = 0;
            while (all_locked && n < 20) begin tick(); n++; end
            total++;
            if (all_locked) begin bad++; $display("FAIL loss_detect: k=%0d al still 1", k); end
            n = 0;
            while (!all_locked && n < 3000) begin tick(); n++; end
            total++;
            if (loss_cnt !== 8'(exp_loss)) begin bad++; $display("FAIL loss_count: got %0d want %0d", loss_cnt, exp_loss); end
            total++;
            if (rst16_cnt != r0 + 1 || strobe_q.size() != s0) begin
                bad++;
                $display("FAIL loss_rerun: rst pulses +%0d strobes +%0d want +1/+0", rst16_cnt - r0, strobe_q.size() - s0);
            end
            total++;
            if (!all_locked || retry_cnt !== 4'd0 || al_rise - last_lock_rise != 4) begin
                bad++;
                $display("FAIL loss_relock: al=%b retry=%0d latency=%0d want 1/0/4", all_locked, retry_cnt, al_rise - last_lock_rise);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit ok;
        for (int q = 0; q < NQ; q++) lock_dly[q] = 500;
        lost_q = 0;
        exp_loss++;
        n = 0;
        while (!qif.QPLLRESET[0] && n < 20) begin tick(); n++; end
        n = 0;
        while (qif.QPLLRESET[0] && n < 40) begin tick(); n++; end
        repeat (10) tick();
        total++;
        if (loss_cnt !== 8'(exp_loss) || all_locked !== 1'b0 || qif.QPLLRESET[0] !== 1'b0) begin
            bad++;
            $display("FAIL midwait_setup: loss=%0d al=%b rst=%b want %0d/0/0", loss_cnt, all_locked, qif.QPLLRESET[0], exp_loss);
        end
        rst = 1'b1;
        tick();
        total++;
        if ({qif.QPLLPD, qif.QPLLRESET, qif.DRPEN, qif.DRPWE, qif.DRPADDR, qif.DRPDI,
             all_locked, fail, retry_cnt, loss_cnt} !== rst_vec_exp) begin
            bad++;
            $display("FAIL midwait_reset: pd=%b rst=%b en=%b al=%b loss=%0d not at reset values",
                     qif.QPLLPD, qif.QPLLRESET, qif.DRPEN, all_locked, loss_cnt);
        end
        exp_loss = 0;
        rst = 1'b0;
        for (int q = 0; q < NQ; q++) lock_dly[q] = $urandom_range(5, 200);
        rdy_dly = 4;
        strobe_q.delete();
        n = 0;
        while (strobe_q.size() < 2 && n < 300) begin tick(); n++; end
        total++;
        if (strobe_q.size() != 2) begin bad++; $display("FAIL midcfg_setup: strobes=%0d want 2", strobe_q.size()); end
        rst = 1'b1;
        tick();
        total++;
        if ({qif.QPLLPD, qif.QPLLRESET, qif.DRPEN, qif.DRPWE, qif.DRPADDR, qif.DRPDI,
             all_locked, fail, retry_cnt, loss_cnt} !== rst_vec_exp) begin
            bad++;
            $display("FAIL midcfg_reset: pd=%b rst=%b en=%b addr=%h not at reset values",
                     qif.QPLLPD, qif.QPLLRESET, qif.DRPEN, qif.DRPADDR);
        end
        strobe_q.delete();
        rst = 1'b0;
        n = 0;
        while (!all_locked && n < 3000) begin tick(); n++; end
        ok = all_locked && strobe_q.size() == NQ;
        for (int i = 0; i < strobe_q.size(); i++) if (strobe_q[i] != i) ok = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL midcfg_rerun: al=%b strobes=%0d want 1 and %0d in order", all_locked, strobe_q.size(), NQ); end
    endtask

    task automatic test_drp_timeout();
        int n;
        rst = 1'b1;
        drp_respond = 1'b0;
        for (int q = 0; q < NQ; q++) lock_dly[q] = $urandom_range(5, 200);
        tick();
        strobe_q.delete();
        proto_bad = 0;
        rst = 1'b0;
        n = 0;
        while (strobe_q.size() < 1 && n < 200) begin tick(); n++; end
        n = 0;
        while (!qif.QPLLRESET[0] && n < 600) begin tick(); n++; end
        total++;
        if (n < DTO || n > DTO + 2) begin bad++; $display("FAIL drp_timeout_time: got %0d cycles want %0d..%0d", n, DTO, DTO+2); end
        total++;
        if (retry_cnt !== 4'd1 || qif.QPLLPD[0] !== 1'b0 || fail !== 1'b0) begin
            bad++;
            $display("FAIL drp_timeout_state: retry=%0d pd=%b fail=%b want 1/0/0", retry_cnt, qif.QPLLPD[0], fail);
        end
        qif.DRPRDY[0] = 1'b1;
        n = 0;
        while (!all_locked && n < 3000) begin tick(); n++; end
        total++;
        if (strobe_q.size() != 1 || !all_locked || retry_cnt !== 4'd0) begin
            bad++;
            $display("FAIL drp_timeout_recover: strobes=%0d al=%b retry=%0d want 1/1/0", strobe_q.size(), all_locked, retry_cnt);
        end
        total++;
        if (proto_bad != 0) begin bad++; $display("FAIL drp_timeout_protocol: violations=%0d want 0", proto_bad); end
        drp_respond = 1'b1;
    endtask

    task automatic test_lock_timeout();
        int n, hi;
        rst = 1'b1;
        rdy_dly = $urandom_range(1, 6);
        for (int q = 0; q < NQ; q++) lock_dly[q] = $urandom_range(5, 200);
        lock_dly[1] = -1;
        tick();
        strobe_q.delete();
        rst16_cnt = 0;
        rst = 1'b0;
        n = 0;
        while (!fail && n < 6000) begin tick(); n++; end
        repeat (50) tick();
        total++;
        if (!fail || retry_cnt !== 4'(MR)) begin bad++; $display("FAIL locktmo_fail: fail=%b retry=%0d want 1/%0d", fail, retry_cnt, MR); end
        total++;
        if (rst16_cnt != MR || strobe_q.size() != NQ) begin
            bad++;
            $display("FAIL locktmo_pulses: rst pulses=%0d strobes=%0d want %0d/%0d", rst16_cnt, strobe_q.size(), MR, NQ);
        end
        total++;
        if (qif.QPLLPD !== {NQ{1'b1}} || qif.QPLLRESET !== {NQ{1'b1}} || all_locked !== 1'b0) begin
            bad++;
            $display("FAIL locktmo_pins: pd=%b rst=%b al=%b want all ones/all ones/0", qif.QPLLPD, qif.QPLLRESET, all_locked);
        end
        lock_dly[1] = $urandom_range(5, 200);
        strobe_q.delete();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        total++;
        if (retry_cnt !== 4'd0) begin bad++; $display("FAIL restart_retry: got %0d want 0", retry_cnt); end
        tick();
        total++;
        if (fail !== 1'b0) begin bad++; $display("FAIL restart_fail: got %b want 0", fail); end
        hi = 2;
        while (qif.QPLLPD[0] && hi < 200) begin tick(); if (qif.QPLLPD[0]) hi++; end
        total++;
        if (hi != PDC) begin bad++; $display("FAIL restart_pd_width: got %0d want %0d", hi, PDC); end
        n = 0;
        while (!all_locked && n < 3000) begin tick(); n++; end
        total++;
        if (!all_locked || strobe_q.size() != NQ || retry_cnt !== 4'd0) begin
            bad++;
            $display("FAIL restart_relock: al=%b strobes=%0d retry=%0d want 1/%0d/0", all_locked, strobe_q.size(), retry_cnt, NQ);
        end
    endtask

    initial begin
        rst_vec_exp = '0;
        rst_vec_exp[28*NQ+13 -: 2*NQ] = '1;
        qif.QPLLLOCK = '0;
        qif.QPLLREFCLKLOST = '0;
        qif.DRPRDY = '0;
        for (int q = 0; q < NQ; q++) lock_dly[q] = 100;
        test_reset();
        test_init();
        test_loss();
        test_reset_mid();
        test_drp_timeout();
        test_lock_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
